pipe_hazard_ctrl: RTL
=====================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 64: maximum number of wait cycles for a data-memory access before the error state is entered.
REQ-002 Parameter CNT_W, default 16: width of the stall performance counter.
REQ-003 Ports: clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 Ports: arst  in  1  reset, asynchronous and active-high.
REQ-005 Ports: id_rs1, id_rs2  in  5 each  source register indices of the instruction in ID.
REQ-006 Ports: ex_rd  in  5  destination register index in ID/EX; ex_memread  in  1  the ID/EX instruction is a load.
REQ-007 Ports: mem_branch_taken  in  1  EX/MEM holds a taken branch (membranch AND zero).
REQ-008 Ports: mem_req  in  1  EX/MEM is issuing a data-memory read or write; mem_ready  in  1  data memory completes the access this cycle.
REQ-009 Ports: pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  enables for the PC register and the four pipeline registers.
REQ-010 Ports: if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  load a bubble (all-zero control) into the named register.
REQ-011 Ports: pc_sel_branch  out  1  PC loads the EX/MEM branch target; err  out  1  sticky timeout error; stall_cnt  out  CNT_W  saturating count of stalled cycles.

Function
REQ-012 FSM states: RUN, MEM_WAIT, ERR; the state is registered and all outputs are combinational from the state plus the current inputs.
REQ-013 Output priority, highest first: arst, ERR, memory wait, branch flush, load-use stall, normal.
REQ-014 Normal (RUN, no event): all enables 1, all flushes 0, pc_sel_branch 0.
REQ-015 Memory wait: in RUN, mem_req=1 and mem_ready=0 drives all five enables to 0 and all flushes to 0, and the next state is MEM_WAIT.
REQ-016 In MEM_WAIT, all enables stay 0 while mem_ready=0, and wait_cnt increments each cycle.
REQ-017 When mem_ready=1 in MEM_WAIT, outputs for that cycle are evaluated as in RUN (branch and load-use rules apply), and the next state is RUN with wait_cnt cleared.
REQ-018 If wait_cnt reaches MEM_TIMEOUT-1 with mem_ready=0, the next state is ERR.
REQ-019 Branch flush: mem_branch_taken=1 outside a memory wait asserts pc_sel_branch, if_id_flush, id_ex_flush and ex_mem_flush, with all enables 1, for exactly that cycle.
REQ-020 A branch that is pending during a wait is honoured in the cycle mem_ready=1, because EX/MEM is frozen during the wait.
REQ-021 Load-use: ex_memread=1, ex_rd!=0 and ex_rd equal to id_rs1 or id_rs2 drives pc_en=0, if_id_en=0 and id_ex_flush=1, with the remaining enables at 1.
REQ-022 The load-use stall lasts one cycle; it clears on its own once the bubble occupies ID/EX.
REQ-023 A branch flush coinciding with a load-use hazard: branch wins and no stall is applied.
REQ-024 ERR: all enables 0, flushes 0, err=1; ERR is left only by arst.
REQ-025 stall_cnt increments in every cycle with pc_en=0 outside arst, and saturates at 2^CNT_W-1 without wrapping.

Reset
REQ-026 While arst=1: state=RUN, wait_cnt=0, stall_cnt=0, err=0, all enables 0, all flushes 0, pc_sel_branch 0.
REQ-027 Assertion of arst mid-wait or in ERR takes effect immediately.
REQ-028 After arst deasserts, the first clock edge begins normal operation.

Structure
REQ-029 Shared package pipe_ctrl_pkg holds the state enum (RUN, MEM_WAIT, ERR) and the register-index width constant REG_IDX_W=5.
REQ-030 One combinational sub-module, lu_hazard_cmp, computes the load-use condition.
REQ-031 wait_cnt width is clog2(MEM_TIMEOUT).

Verification
REQ-032 ex_memread=1, ex_rd=5, id_rs2=5 -> one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; then normal; stall_cnt=1.
REQ-033 ex_memread=1, ex_rd=0, id_rs1=0 -> no stall, all enables 1.
REQ-034 mem_req=1 with mem_ready low for 3 cycles, then high -> all enables 0 for 3 cycles, then 1; stall_cnt=3; state returns to RUN.
REQ-035 mem_branch_taken=1 together with a load-use hazard -> pc_sel_branch=1, three flushes=1, pc_en=1 for one cycle.
REQ-036 MEM_TIMEOUT=4, mem_ready held 0 -> ERR entered after 4 wait cycles; err=1; arst pulse -> err=0, state RUN.
REQ-037 CNT_W=4, 20 stall cycles -> stall_cnt=15 and holds.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

   localparam int unsigned REG_IDX_W = 5;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERR      = 2'd2
   } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller: decode/memory status in, enables out.
interface pipe_hazard_ctrl_if #(
   parameter int unsigned CNT_W = 16
);
   logic [pipe_ctrl_pkg::REG_IDX_W-1:0] id_rs1;
   logic [pipe_ctrl_pkg::REG_IDX_W-1:0] id_rs2;
   logic [pipe_ctrl_pkg::REG_IDX_W-1:0] ex_rd;
   logic                                ex_memread;
   logic                                mem_branch_taken;
   logic                                mem_req;
   logic                                mem_ready;

   logic             pc_en;
   logic             if_id_en;
   logic             id_ex_en;
   logic             ex_mem_en;
   logic             mem_wb_en;
   logic             if_id_flush;
   logic             id_ex_flush;
   logic             ex_mem_flush;
   logic             pc_sel_branch;
   logic             err;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output id_rs1, id_rs2, ex_rd, ex_memread, mem_branch_taken, mem_req, mem_ready,
      input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
      input  if_id_flush, id_ex_flush, ex_mem_flush, pc_sel_branch, err, stall_cnt
   );

   modport slave (
      input  id_rs1, id_rs2, ex_rd, ex_memread, mem_branch_taken, mem_req, mem_ready,
      output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
      output if_id_flush, id_ex_flush, ex_mem_flush, pc_sel_branch, err, stall_cnt
   );

endinterface

// File: rtl/pipe_hazard_ctrl_lu_hazard_cmp.sv
// Load-use hazard detect: a load in ID/EX writes a register that the ID instruction reads.
module lu_hazard_cmp
   import pipe_ctrl_pkg::*;
(
   input  logic [REG_IDX_W-1:0] i_id_rs1,
   input  logic [REG_IDX_W-1:0] i_id_rs2,
   input  logic [REG_IDX_W-1:0] i_ex_rd,
   input  logic                 i_ex_memread,
   output logic                 o_hazard
);

   // x0 is hardwired to zero, so a load targeting it never creates a dependency.
   assign o_hazard = i_ex_memread && (i_ex_rd != '0) &&
                     ((i_ex_rd == i_id_rs1) || (i_ex_rd == i_id_rs2));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze with timeout, branch flush, load-use stall,
// and a saturating stall counter.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 64,
   parameter int unsigned CNT_W       = 16
) (
   input  logic           clk,
   input  logic           arst,
   pipe_hazard_ctrl_if.slave bus
);

   localparam int unsigned      WAIT_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   state_e              r_state;
   logic [WAIT_W-1:0]   r_wait_cnt;
   logic [CNT_W-1:0]    r_stall_cnt;

   state_e              w_state_d;
   logic [WAIT_W-1:0]   w_wait_d;
   logic                w_lu_hazard;
   logic                w_mem_wait;
   logic                w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en, w_mem_wb_en;
   logic                w_if_id_flush, w_id_ex_flush, w_ex_mem_flush, w_pc_sel_branch, w_err;

   lu_hazard_cmp u_lu_hazard_cmp (
      .i_id_rs1     (bus.id_rs1),
      .i_id_rs2     (bus.id_rs2),
      .i_ex_rd      (bus.ex_rd),
      .i_ex_memread (bus.ex_memread),
      .o_hazard     (w_lu_hazard)
   );

   // Once waiting, only mem_ready ends the freeze; mem_req is frozen in EX/MEM anyway.
   assign w_mem_wait = (r_state == MEM_WAIT) ? !bus.mem_ready
                                             : (bus.mem_req && !bus.mem_ready);

   always_comb begin
      w_state_d       = r_state;
      w_wait_d        = r_wait_cnt;
      w_pc_en         = 1'b0;
      w_if_id_en      = 1'b0;
      w_id_ex_en      = 1'b0;
      w_ex_mem_en     = 1'b0;
      w_mem_wb_en     = 1'b0;
      w_if_id_flush   = 1'b0;
      w_id_ex_flush   = 1'b0;
      w_ex_mem_flush  = 1'b0;
      w_pc_sel_branch = 1'b0;
      w_err           = 1'b0;
      if (!arst) begin
         unique case (r_state)
            RUN, MEM_WAIT: begin
               if (w_mem_wait) begin
                  if (r_state == RUN) begin
                     // The RUN cycle that detects the miss is the first wait cycle.
                     w_state_d = (MEM_TIMEOUT <= 1) ? ERR : MEM_WAIT;
                     w_wait_d  = WAIT_W'(1);
                  end else if (r_wait_cnt == WAIT_LAST) begin
                     w_state_d = ERR;
                  end else begin
                     w_wait_d = r_wait_cnt + WAIT_W'(1);
                  end
               end else begin
                  w_state_d   = RUN;
                  w_wait_d    = '0;
                  w_pc_en     = 1'b1;
                  w_if_id_en  = 1'b1;
                  w_id_ex_en  = 1'b1;
                  w_ex_mem_en = 1'b1;
                  w_mem_wb_en = 1'b1;
                  if (bus.mem_branch_taken) begin
                     w_pc_sel_branch = 1'b1;
                     w_if_id_flush   = 1'b1;
                     w_id_ex_flush   = 1'b1;
                     w_ex_mem_flush  = 1'b1;
                  end else if (w_lu_hazard) begin
                     w_pc_en       = 1'b0;
                     w_if_id_en    = 1'b0;
                     w_id_ex_flush = 1'b1;
                  end
               end
            end
            ERR:     w_err = 1'b1;
            default: w_state_d = ERR;
         endcase
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_state     <= RUN;
         r_wait_cnt  <= '0;
         r_stall_cnt <= '0;
      end else begin
         r_state    <= w_state_d;
         r_wait_cnt <= w_wait_d;
         if (!w_pc_en && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         end
      end
   end

   assign bus.pc_en         = w_pc_en;
   assign bus.if_id_en      = w_if_id_en;
   assign bus.id_ex_en      = w_id_ex_en;
   assign bus.ex_mem_en     = w_ex_mem_en;
   assign bus.mem_wb_en     = w_mem_wb_en;
   assign bus.if_id_flush   = w_if_id_flush;
   assign bus.id_ex_flush   = w_id_ex_flush;
   assign bus.ex_mem_flush  = w_ex_mem_flush;
   assign bus.pc_sel_branch = w_pc_sel_branch;
   assign bus.err           = w_err;
   assign bus.stall_cnt     = r_stall_cnt;

endmodule
